// File: rtl/exu_issue_ctrl_ysyx23060136_if.sv
// Handshake bundle between the EXU issue controller and its ID/MDU/MEM neighbours.
// slave = controller side, master = surrounding pipeline.
interface exu_issue_ctrl_ysyx23060136_if #(
  parameter int CNT_W = 32
);
  logic             id_valid;
  logic             id_is_mdu;
  logic             exu_ready;
  logic             exu_load_en;
  logic             branch_taken;
  logic             flush_if;
  logic             flush_id;
  logic             mdu_start;
  logic             mdu_done;
  logic             mdu_flush;
  logic             mem_ready;
  logic             exu_valid;
  logic             mdu_timeout;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output id_valid, id_is_mdu, branch_taken, mdu_done, mem_ready,
    input  exu_ready, exu_load_en, flush_if, flush_id, mdu_start, mdu_flush,
           exu_valid, mdu_timeout, stall_cycles
  );

  modport slave (
    input  id_valid, id_is_mdu, branch_taken, mdu_done, mem_ready,
    output exu_ready, exu_load_en, flush_if, flush_id, mdu_start, mdu_flush,
           exu_valid, mdu_timeout, stall_cycles
  );
endinterface

// File: rtl/exu_issue_ctrl_ysyx23060136.sv
// EXU sequencer: owns stage valid, ID/EXU load, MDU issue + watchdog, one-shot branch flush.
// Latency 1 cycle (ALU) or until mdu_done; holds result while mem_ready=0, no accept meanwhile.
module exu_issue_ctrl_ysyx23060136 #(
  parameter int MDU_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input logic clk,
  input logic rst_n,
  exu_issue_ctrl_ysyx23060136_if.slave bus
);

  localparam int WDOG_W = (MDU_TIMEOUT > 2) ? $clog2(MDU_TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EXEC     = 2'd1,
    MDU_WAIT = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [WDOG_W-1:0] wdog;
  logic [CNT_W-1:0]  stall_q;
  logic              timeout_q;

  logic in_st_idle;
  logic in_st_exec;
  logic in_st_mdu;
  logic exu_ready;
  logic in_fire;
  logic out_fire;
  logic branch_flush;
  logic wdog_expired;
  logic timeout_hit;
  logic stall_inc;

  assign in_st_idle = (state == IDLE);
  assign in_st_exec = (state == EXEC);
  assign in_st_mdu  = (state == MDU_WAIT);

  // A taken branch must leave before anything younger is accepted behind it.
  assign exu_ready    = in_st_idle | (in_st_exec & bus.mem_ready & ~bus.branch_taken);
  assign in_fire      = bus.id_valid & exu_ready;
  assign out_fire     = in_st_exec & bus.mem_ready;
  assign branch_flush = out_fire & bus.branch_taken;

  assign wdog_expired = (wdog == WDOG_W'(MDU_TIMEOUT - 1));
  // A completion on the expiry cycle wins over the watchdog.
  assign timeout_hit  = in_st_mdu & ~bus.mdu_done & wdog_expired;
  assign stall_inc    = (in_st_exec & ~bus.mem_ready) | in_st_mdu;

  assign bus.exu_ready    = exu_ready;
  assign bus.exu_load_en  = in_fire;
  assign bus.exu_valid    = in_st_exec;
  assign bus.flush_if     = branch_flush;
  assign bus.flush_id     = branch_flush;
  assign bus.mdu_start    = in_st_mdu & (wdog == '0);
  assign bus.mdu_flush    = timeout_hit;
  assign bus.mdu_timeout  = timeout_q;
  assign bus.stall_cycles = stall_q;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (in_fire) state_nxt = bus.id_is_mdu ? MDU_WAIT : EXEC;
      end
      EXEC: begin
        if (out_fire) begin
          if (in_fire) state_nxt = bus.id_is_mdu ? MDU_WAIT : EXEC;
          else         state_nxt = IDLE;
        end
      end
      MDU_WAIT: begin
        if (bus.mdu_done || wdog_expired) state_nxt = EXEC;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      wdog      <= '0;
      stall_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (in_st_mdu && state_nxt == MDU_WAIT) wdog <= wdog + WDOG_W'(1);
      else                                    wdog <= '0;
      if (timeout_hit) timeout_q <= 1'b1;
      if (stall_inc && stall_q != '1) stall_q <= stall_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_exu_issue_ctrl_ysyx23060136.sv
// Directed cycle table plus hand sequences for watchdog, reset and counter saturation.
module tb_exu_issue_ctrl_ysyx23060136;

  logic clk;
  logic rst_n;
  logic rst_n_s;

  exu_issue_ctrl_ysyx23060136_if #(.CNT_W(32)) bus ();
  exu_issue_ctrl_ysyx23060136_if #(.CNT_W(4))  bus_s ();

  exu_issue_ctrl_ysyx23060136 #(.MDU_TIMEOUT(64), .CNT_W(32)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  exu_issue_ctrl_ysyx23060136 #(.MDU_TIMEOUT(64), .CNT_W(4)) dut_s (
    .clk  (clk),
    .rst_n(rst_n_s),
    .bus  (bus_s)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // stim = {id_valid, id_is_mdu, branch_taken, mdu_done, mem_ready}
  // expv = {exu_ready, exu_load_en, flush, mdu_start, mdu_flush, exu_valid, mdu_timeout}
  typedef struct {
    bit [4:0]    stim;
    bit [6:0]    expv;
    logic [31:0] stall;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  task automatic add(input bit [4:0] s, input bit [6:0] e, input int st);
    vec_t v;
    v.stim  = s;
    v.expv  = e;
    v.stall = st;
    vecs.push_back(v);
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic checkn(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input bit [4:0] s);
    {bus.id_valid, bus.id_is_mdu, bus.branch_taken, bus.mdu_done, bus.mem_ready} = s;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Streaming: EXEC every cycle, one accept per cycle.
    for (int i = 0; i < 10; i++) add(5'b10001, 7'b1100010, 0);
    // Backpressure with a taken branch: flush only on the leaving cycle.
    add(5'b10100, 7'b0000010, 0);
    add(5'b10100, 7'b0000010, 1);
    add(5'b10100, 7'b0000010, 2);
    add(5'b10101, 7'b0010010, 3);
    add(5'b00000, 7'b1000000, 3);
    // MDU op, done in the fifth wait cycle.
    add(5'b11001, 7'b1100000, 3);
    add(5'b10000, 7'b0001000, 3);
    add(5'b10100, 7'b0000000, 4);
    add(5'b10000, 7'b0000000, 5);
    add(5'b10000, 7'b0000000, 6);
    add(5'b10010, 7'b0000000, 7);
    add(5'b10001, 7'b1100010, 8);
    add(5'b00001, 7'b1000010, 8);
    add(5'b00000, 7'b1000000, 8);
    // Back-to-back into MDU with done on the first wait cycle.
    add(5'b10001, 7'b1100000, 8);
    add(5'b11001, 7'b1100010, 8);
    add(5'b00010, 7'b0001000, 8);
    add(5'b00000, 7'b0000010, 9);
    add(5'b00001, 7'b1000010, 10);
    add(5'b00101, 7'b1000000, 10);

    rst_n   = 1'b0;
    rst_n_s = 1'b0;
    drive(5'b10000);
    {bus_s.id_valid, bus_s.id_is_mdu, bus_s.branch_taken, bus_s.mdu_done, bus_s.mem_ready} = 5'b00000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check1("rst exu_valid", bus.exu_valid, 1'b0);
    check1("rst exu_ready", bus.exu_ready, 1'b1);
    check1("rst mdu_timeout", bus.mdu_timeout, 1'b0);
    check1("rst flush_if", bus.flush_if, 1'b0);
    check1("rst mdu_start", bus.mdu_start, 1'b0);
    checkn("rst stall_cycles", bus.stall_cycles, 0);
    rst_n = 1'b1;
    #1;
    check1("release exu_load_en", bus.exu_load_en, 1'b1);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].stim);
      #1;
      check1($sformatf("v%0d exu_ready", i),   bus.exu_ready,   vecs[i].expv[6]);
      check1($sformatf("v%0d exu_load_en", i), bus.exu_load_en, vecs[i].expv[5]);
      check1($sformatf("v%0d flush_if", i),    bus.flush_if,    vecs[i].expv[4]);
      check1($sformatf("v%0d flush_id", i),    bus.flush_id,    vecs[i].expv[4]);
      check1($sformatf("v%0d mdu_start", i),   bus.mdu_start,   vecs[i].expv[3]);
      check1($sformatf("v%0d mdu_flush", i),   bus.mdu_flush,   vecs[i].expv[2]);
      check1($sformatf("v%0d exu_valid", i),   bus.exu_valid,   vecs[i].expv[1]);
      check1($sformatf("v%0d mdu_timeout", i), bus.mdu_timeout, vecs[i].expv[0]);
      checkn($sformatf("v%0d stall_cycles", i), bus.stall_cycles, vecs[i].stall);
    end

    // Watchdog expiry: flush on the 64th wait cycle, error sticks.
    @(negedge clk);
    drive(5'b11001);
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      drive(5'b00000);
      #1;
      check1($sformatf("wd%0d mdu_start", k), bus.mdu_start, k == 1);
      check1($sformatf("wd%0d mdu_flush", k), bus.mdu_flush, k == 64);
      check1($sformatf("wd%0d exu_ready", k), bus.exu_ready, 1'b0);
      check1($sformatf("wd%0d mdu_timeout", k), bus.mdu_timeout, 1'b0);
    end
    @(negedge clk);
    drive(5'b00001);
    #1;
    check1("wd exit exu_valid", bus.exu_valid, 1'b1);
    check1("wd exit mdu_timeout", bus.mdu_timeout, 1'b1);
    check1("wd exit mdu_flush", bus.mdu_flush, 1'b0);
    checkn("wd exit stall_cycles", bus.stall_cycles, 74);
    repeat (3) @(negedge clk);
    #1;
    check1("wd sticky mdu_timeout", bus.mdu_timeout, 1'b1);
    check1("wd idle exu_valid", bus.exu_valid, 1'b0);

    // Reset clears the sticky error; then done coincides with expiry.
    @(negedge clk);
    rst_n = 1'b0;
    drive(5'b00000);
    @(negedge clk);
    #1;
    check1("rst2 mdu_timeout", bus.mdu_timeout, 1'b0);
    checkn("rst2 stall_cycles", bus.stall_cycles, 0);
    rst_n = 1'b1;
    drive(5'b11001);
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      drive((k == 64) ? 5'b00010 : 5'b00000);
      #1;
      if (k == 64) check1("coinc mdu_flush", bus.mdu_flush, 1'b0);
    end
    @(negedge clk);
    drive(5'b00001);
    #1;
    check1("coinc exu_valid", bus.exu_valid, 1'b1);
    check1("coinc mdu_timeout", bus.mdu_timeout, 1'b0);
    checkn("coinc stall_cycles", bus.stall_cycles, 64);

    // Saturation on the 4-bit counter instance.
    @(negedge clk);
    rst_n_s = 1'b1;
    {bus_s.id_valid, bus_s.id_is_mdu, bus_s.branch_taken, bus_s.mdu_done, bus_s.mem_ready} = 5'b11001;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      {bus_s.id_valid, bus_s.id_is_mdu, bus_s.branch_taken, bus_s.mdu_done, bus_s.mem_ready} = 5'b00000;
      #1;
      if (k == 15) checkn("sat k15 stall_cycles", 32'(bus_s.stall_cycles), 14);
      if (k == 17) checkn("sat k17 stall_cycles", 32'(bus_s.stall_cycles), 15);
    end
    @(negedge clk);
    #1;
    checkn("sat end stall_cycles", 32'(bus_s.stall_cycles), 15);
    check1("sat mdu_flush idle", bus_s.mdu_flush, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
